apb_wr_capture_fifo: RTL and testbench
======================================

// Module: apb_wr_capture_fifo
// PURPOSE
//  APB3 completer sitting directly downstream of the AXI-to-APB write bridge. Captures every
//  APB write hitting its address window into a DEPTH-entry FIFO and replays it on a
//  valid/ready stream. Flags the start of each incrementing burst; reports overflow and drops.
//  The bridge has no wait-state input, so PREADY is constant 1 and full-FIFO writes are dropped.
// PARAMETERS
//  ADDR_W     32            PADDR / out_addr width
//  DATA_W     32            PWDATA / out_data width
//  DEPTH      8             FIFO entries; power of 2, >=2
//  BASE_ADDR  32'h0000_0000 window base, compared under ADDR_MASK
//  ADDR_MASK  32'h0000_0000 1-bits are compared against BASE_ADDR; all-zero = match any address
//  CNT_W      8             drop_count width
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset, synchronous, active-low
//  PSEL         in   1        APB select
//  PENABLE      in   1        APB access phase
//  PWRITE       in   1        APB direction, 1 = write
//  PADDR        in   ADDR_W   APB address
//  PWDATA       in   DATA_W   APB write data
//  PREADY       out  1        constant 1; no wait states
//  PSLVERR      out  1        error on current access phase (combinational)
//  out_valid    out  1        FIFO head valid
//  out_ready    in   1        consumer accepts head
//  out_addr     out  ADDR_W   captured PADDR
//  out_data     out  DATA_W   captured PWDATA
//  out_first    out  1        head entry starts a burst
//  level        out  $clog2(DEPTH)+1   current occupancy
//  overflow     out  1        sticky; set on any drop
//  drop_count   out  CNT_W    saturating count of dropped writes
//  clr_status   in   1        clears overflow and drop_count (one cycle)
// BEHAVIOUR
//  - Reset: FIFO empty, out_valid=0, level=0, overflow=0, drop_count=0, burst tracker invalid,
//    out_addr/out_data/out_first=0. Reset mid-burst discards all contents; later beats are new entries.
//  - access = PSEL & PENABLE; hit = ((PADDR ^ BASE_ADDR) & ADDR_MASK) == 0.
//  - push = access & PWRITE & hit & (!full | pop); pop = out_valid & out_ready.
//  - PSLVERR = access & (!PWRITE | !hit | (full & !pop)); 0 outside the access phase.
//  - Setup phase (PSEL & !PENABLE) has no effect; exactly one push per access phase.
//  - Drop (access & PWRITE & hit & full & !pop): overflow<=1; drop_count+1, saturating at all-ones.
//  - Drop and clr_status in the same cycle: drop wins (overflow=1, drop_count=1).
//  - Latency: a push at edge N gives out_valid=1 after edge N when the FIFO was empty. No
//    combinational bypass; outputs come from registered head storage.
//  - push & pop in the same cycle: level unchanged; allowed when full; when empty only push occurs.
//  - out_first = 1 when the tracker is invalid or PADDR != last_addr + 4 (mod 2^ADDR_W).
//    Tracker (last_addr) updates on every push and is not updated by drops, misses or reads.
//  - Read accesses: no FIFO effect, PSLVERR=1. There is no PRDATA port.
//  - Pointers wrap modulo DEPTH; full/empty come from an extra wrap bit; level = wr_ptr - rd_ptr.
//  - out_* stay stable while out_valid & !out_ready.
// STRUCTURE
//  - apb_pkg: apb_req_t {psel, penable, pwrite, paddr, pwdata}, cap_entry_t {addr, data, first},
//    APB_ADDR_STRIDE = 4.
//  - Sub-module sync_fifo #(type T, DEPTH): registered storage, push/pop/full/empty/level.
//    Top level holds the decode, burst tracker, PSLVERR and status counters.
// TESTING
//  1. 4-beat burst at 0xaabbccdd, data 12345678/2468ACF0/369D0368/48D159E0, out_ready=1
//     -> 4 entries in order, addresses +4 each, out_first=1 on beat 0 only, PSLVERR=0.
//  2. Second burst at 0xeeffaabb right after test 1 -> its first beat has out_first=1.
//  3. DEPTH=8, out_ready=0, 10 writes -> level=8, PSLVERR on writes 9-10, drop_count=2,
//     overflow=1; drain -> first 8 in order; clr_status -> overflow=0, drop_count=0.
//  4. FIFO full, write with out_ready=1 in the same cycle -> accepted, level stays 8, no PSLVERR.
//  5. BASE_ADDR=0x4000_0000, ADDR_MASK=0xF000_0000, write 0x5000_0000 -> PSLVERR=1, level=0;
//     read access -> PSLVERR=1, level=0.
//  6. rst_n=0 for 1 cycle after beat 2 of a burst -> level=0, out_valid=0; beat 3 gives out_first=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB write-capture FIFO: the incoming APB request bundle,
// the captured FIFO entry, and the address stride that defines an incrementing burst.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Consecutive beats of one incrementing burst are one 32-bit word apart
   localparam logic [APB_ADDR_W-1:0] APB_ADDR_STRIDE = 32'd4;

   typedef struct packed {
      logic                  psel;
      logic                  penable;
      logic                  pwrite;
      logic [APB_ADDR_W-1:0] paddr;
      logic [APB_DATA_W-1:0] pwdata;
   } apb_req_t;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] data;
      logic                  first;
   } cap_entry_t;

endpackage

// File: rtl/apb_wr_capture_fifo_sync_fifo.sv
// Generic synchronous FIFO with registered storage. Pointers carry one extra wrap
// bit so that full and empty can be told apart when the index bits are equal.
// The head is read straight out of the storage registers; nothing written in the
// current cycle can reach rd_data before the next clock edge.
module sync_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  T                       wr_data,
   output T                       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   // Storage and pointers; reset also zeroes the storage so the head reads as zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_data;
            wr_ptr                 <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rd_data = mem[rd_ptr[PTR_W-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/apb_wr_capture_fifo.sv
// APB3 completer that captures every write landing in its address window into a
// FIFO and replays it on a valid/ready stream. The upstream bridge cannot stall,
// so PREADY is tied high and a write arriving at a full FIFO is dropped and
// reported through PSLVERR, the sticky overflow flag and a saturating drop counter.
// Each entry is tagged with whether it starts a new incrementing burst.
module apb_wr_capture_fifo
   import apb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] ADDR_MASK = 32'h0000_0000,
   parameter int                CNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [ADDR_W-1:0]      PADDR,
   input  logic [DATA_W-1:0]      PWDATA,
   output logic                   PREADY,
   output logic                   PSLVERR,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_addr,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_first,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [CNT_W-1:0]       drop_count,
   input  logic                   clr_status
);

   apb_req_t          req;
   cap_entry_t        wr_entry;
   cap_entry_t        head;
   logic              access;
   logic              hit;
   logic              wr_access;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              drop;
   logic              first;
   logic              trk_valid;
   logic [ADDR_W-1:0] last_addr;

   assign req = '{psel: PSEL, penable: PENABLE, pwrite: PWRITE, paddr: PADDR, pwdata: PWDATA};

   // A mask of all zeros compares no bits, so every address is inside the window
   assign access    = req.psel & req.penable;
   assign hit       = (((req.paddr ^ BASE_ADDR) & ADDR_MASK) == '0);
   assign wr_access = access & req.pwrite & hit;

   // A full FIFO still accepts a write when the consumer frees a slot in the same cycle
   assign pop  = ~empty & out_ready;
   assign push = wr_access & (~full | pop);
   assign drop = wr_access & full & ~pop;

   assign PREADY  = 1'b1;
   assign PSLVERR = access & (~req.pwrite | ~hit | (full & ~pop));

   assign first    = ~trk_valid | (req.paddr != last_addr + APB_ADDR_STRIDE);
   assign wr_entry = '{addr: req.paddr, data: req.pwdata, first: first};

   sync_fifo #(
      .T     (cap_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign out_valid = ~empty;
   assign out_addr  = head.addr;
   assign out_data  = head.data;
   assign out_first = head.first;

   // Burst tracker follows accepted writes only; dropped, missed and read accesses leave it alone
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trk_valid <= 1'b0;
         last_addr <= '0;
      end else if (push) begin
         trk_valid <= 1'b1;
         last_addr <= req.paddr;
      end
   end

   // Overflow status; a drop in the same cycle as a clear still registers as one fresh drop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_status) begin
            drop_count <= CNT_W'(1);
         end else if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
         end
      end else if (clr_status) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_apb_wr_capture_fifo.sv
// Testbench for apb_wr_capture_fifo. A queue-based reference model tracks the
// expected FIFO contents, burst tracking and drop status; directed scenarios and a
// randomized phase compare the design against it. A second instance with a
// restricted address window covers the address-decode behaviour.
module tb_apb_wr_capture_fifo;
   import apb_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             psel = 1'b0;
   logic             penable = 1'b0;
   logic             pwrite = 1'b0;
   logic [31:0]      paddr = '0;
   logic [31:0]      pwdata = '0;
   logic             out_ready = 1'b0;
   logic             clr_status = 1'b0;

   logic             pready, pslverr, out_valid, out_first, overflow;
   logic [31:0]      out_addr, out_data;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] drop_count;

   logic             w_pready, w_pslverr, w_out_valid, w_out_first, w_overflow;
   logic [31:0]      w_out_addr, w_out_data;
   logic [LVL_W-1:0] w_level;
   logic [CNT_W-1:0] w_drop_count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        first;
   } exp_t;

   exp_t        q[$];
   bit          m_trk_valid;
   logic [31:0] m_last;
   bit          m_ovf;
   int          m_drops;

   int          checks = 0;
   int          failures = 0;
   logic        last_err;
   logic        last_w_err;

   apb_wr_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready), .PSLVERR(pslverr),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_first(out_first), .level(level),
      .overflow(overflow), .drop_count(drop_count), .clr_status(clr_status)
   );

   apb_wr_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W),
                         .BASE_ADDR(32'h4000_0000), .ADDR_MASK(32'hF000_0000)) dut_win (
      .clk(clk), .rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(w_pready), .PSLVERR(w_pslverr),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr),
      .out_data(w_out_data), .out_first(w_out_first), .level(w_level),
      .overflow(w_overflow), .drop_count(w_drop_count), .clr_status(clr_status)
   );

   always #5 clk = ~clk;

   // Reference model for the default-window instance: applies the current inputs at the next edge
   function automatic void model_edge();
      bit access, full, pop, wr, dropped;
      if (!rst_n) begin
         q.delete();
         m_trk_valid = 0;
         m_last      = '0;
         m_ovf       = 0;
         m_drops     = 0;
         return;
      end
      access  = psel && penable;
      full    = (q.size() == DEPTH);
      pop     = (q.size() != 0) && out_ready;
      wr      = access && pwrite;
      dropped = wr && full && !pop;
      if (pop) void'(q.pop_front());
      if (wr && !dropped) begin
         q.push_back('{paddr, pwdata, (!m_trk_valid || paddr != m_last + 32'd4)});
         m_trk_valid = 1;
         m_last      = paddr;
      end
      if (dropped) begin
         m_ovf   = 1;
         m_drops = clr_status ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
      end else if (clr_status) begin
         m_ovf   = 0;
         m_drops = 0;
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      psel = 0; penable = 0; clr_status = 0; out_ready = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   // One full APB access (setup + access phase) with state checks against the model
   task automatic apb_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input bit rdy_setup, input bit rdy_access, input bit clr);
      bit exp_err;
      psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
      out_ready = rdy_setup; clr_status = 0;
      tick();
      penable = 1; out_ready = rdy_access; clr_status = clr;
      #1;
      exp_err    = !wr || (q.size() == DEPTH && !(q.size() != 0 && rdy_access));
      last_err   = pslverr;
      last_w_err = w_pslverr;
      checks++;
      if (pslverr !== exp_err) begin
         failures++;
         $display("[TB] FAIL pslverr addr=%h: got %b want %b", addr, pslverr, exp_err);
      end
      tick();
      psel = 0; penable = 0; clr_status = 0;
      checks++;
      if (level !== LVL_W'(q.size()) || out_valid !== (q.size() != 0)) begin
         failures++;
         $display("[TB] FAIL occupancy: got level=%0d valid=%b want level=%0d valid=%b",
                  level, out_valid, q.size(), q.size() != 0);
      end
      if (q.size() != 0) begin
         checks++;
         if (out_addr !== q[0].addr || out_data !== q[0].data || out_first !== q[0].first) begin
            failures++;
            $display("[TB] FAIL head: got %h/%h/%b want %h/%h/%b", out_addr, out_data,
                     out_first, q[0].addr, q[0].data, q[0].first);
         end
      end
      checks++;
      if (overflow !== m_ovf || drop_count !== CNT_W'(m_drops)) begin
         failures++;
         $display("[TB] FAIL status: got ovf=%b drops=%0d want ovf=%b drops=%0d",
                  overflow, drop_count, m_ovf, m_drops);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      checks++;
      if (out_valid !== 0 || level !== 0 || overflow !== 0 || drop_count !== 0 ||
          out_addr !== 0 || out_data !== 0 || out_first !== 0 || pready !== 1) begin
         failures++;
         $display("[TB] FAIL reset_state: got v=%b lvl=%0d ovf=%b drops=%0d a=%h d=%h f=%b rdy=%b",
                  out_valid, level, overflow, drop_count, out_addr, out_data, out_first, pready);
      end
   endtask

   task automatic test_burst();
      logic [31:0] dat [4];
      logic [31:0] base;
      dat[0] = 32'h12345678; dat[1] = 32'h2468ACF0; dat[2] = 32'h369D0368; dat[3] = 32'h48D159E0;
      base = 32'haabbccdd;
      for (int i = 0; i < 4; i++) begin
         apb_access(1, base + 32'(4 * i), dat[i], 1, 1, 0);
         checks++;
         if (last_err !== 0 || out_valid !== 1 || out_addr !== base + 32'(4 * i) ||
             out_data !== dat[i] || out_first !== (i == 0)) begin
            failures++;
            $display("[TB] FAIL burst_beat%0d: got err=%b v=%b %h/%h/%b want 0 1 %h/%h/%b", i,
                     last_err, out_valid, out_addr, out_data, out_first,
                     base + 32'(4 * i), dat[i], i == 0);
         end
      end
   endtask

   task automatic test_second_burst();
      apb_access(1, 32'heeffaabb, 32'h0badf00d, 1, 1, 0);
      checks++;
      if (out_first !== 1 || out_addr !== 32'heeffaabb) begin
         failures++;
         $display("[TB] FAIL second_burst_first: got f=%b a=%h want 1 eeffaabb", out_first, out_addr);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] saved [10];
      out_ready = 1;
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         saved[i] = $urandom;
         apb_access(1, 32'h1000 + 32'(4 * i), saved[i], 0, 0, 0);
         checks++;
         if (last_err !== (i >= 8)) begin
            failures++;
            $display("[TB] FAIL overflow_err%0d: got %b want %b", i, last_err, i >= 8);
         end
      end
      checks++;
      if (level !== 8 || drop_count !== 2 || overflow !== 1) begin
         failures++;
         $display("[TB] FAIL overflow_status: got lvl=%0d drops=%0d ovf=%b want 8 2 1",
                  level, drop_count, overflow);
      end
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1 || out_addr !== 32'h1000 + 32'(4 * i) || out_data !== saved[i]) begin
            failures++;
            $display("[TB] FAIL drain%0d: got v=%b %h/%h want 1 %h/%h", i, out_valid, out_addr,
                     out_data, 32'h1000 + 32'(4 * i), saved[i]);
         end
         tick();
      end
      out_ready = 0;
      checks++;
      if (level !== 0 || out_valid !== 0) begin
         failures++;
         $display("[TB] FAIL drained_empty: got lvl=%0d v=%b want 0 0", level, out_valid);
      end
      clr_status = 1;
      tick();
      clr_status = 0;
      checks++;
      if (overflow !== 0 || drop_count !== 0) begin
         failures++;
         $display("[TB] FAIL clr_status: got ovf=%b drops=%0d want 0 0", overflow, drop_count);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 8; i++) begin
         apb_access(1, 32'h2000 + 32'(4 * i), $urandom, 0, 0, 0);
      end
      apb_access(1, 32'h2020, 32'hcafe0001, 0, 1, 0);
      checks++;
      if (last_err !== 0 || level !== 8 || overflow !== 0) begin
         failures++;
         $display("[TB] FAIL full_push_pop: got err=%b lvl=%0d ovf=%b want 0 8 0",
                  last_err, level, overflow);
      end
      apb_access(1, 32'h2024, 32'hcafe0002, 0, 0, 1);
      checks++;
      if (last_err !== 1 || overflow !== 1 || drop_count !== 1) begin
         failures++;
         $display("[TB] FAIL drop_vs_clr: got err=%b ovf=%b drops=%0d want 1 1 1",
                  last_err, overflow, drop_count);
      end
   endtask

   task automatic test_window();
      do_reset();
      apb_access(1, 32'h5000_0000, 32'h11111111, 0, 0, 0);
      checks++;
      if (last_w_err !== 1 || w_level !== 0) begin
         failures++;
         $display("[TB] FAIL window_miss: got err=%b lvl=%0d want 1 0", last_w_err, w_level);
      end
      apb_access(0, 32'h4000_0010, 32'h0, 0, 0, 0);
      checks++;
      if (last_w_err !== 1 || w_level !== 0 || last_err !== 1) begin
         failures++;
         $display("[TB] FAIL window_read: got err=%b lvl=%0d dflt_err=%b want 1 0 1",
                  last_w_err, w_level, last_err);
      end
      apb_access(1, 32'h4abc_1234, 32'h22222222, 0, 0, 0);
      checks++;
      if (last_w_err !== 0 || w_level !== 1 || w_out_addr !== 32'h4abc_1234 || w_out_first !== 1) begin
         failures++;
         $display("[TB] FAIL window_hit: got err=%b lvl=%0d a=%h f=%b want 0 1 4abc1234 1",
                  last_w_err, w_level, w_out_addr, w_out_first);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apb_access(1, 32'h3000 + 32'(4 * i), $urandom, 0, 0, 0);
      end
      rst_n = 0;
      tick();
      rst_n = 1;
      checks++;
      if (level !== 0 || out_valid !== 0) begin
         failures++;
         $display("[TB] FAIL mid_burst_reset: got lvl=%0d v=%b want 0 0", level, out_valid);
      end
      apb_access(1, 32'h300c, 32'h33333333, 0, 0, 0);
      checks++;
      if (out_first !== 1 || level !== 1) begin
         failures++;
         $display("[TB] FAIL post_reset_first: got f=%b lvl=%0d want 1 1", out_first, level);
      end
   endtask

   task automatic test_random();
      logic [31:0] next_addr;
      int          r;
      do_reset();
      next_addr = $urandom;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            out_ready  = ($urandom_range(0, 1) == 1);
            clr_status = ($urandom_range(0, 15) == 0);
            tick();
            clr_status = 0;
            checks++;
            if (level !== LVL_W'(q.size()) || overflow !== m_ovf || drop_count !== CNT_W'(m_drops)) begin
               failures++;
               $display("[TB] FAIL random_idle: got lvl=%0d ovf=%b drops=%0d want %0d %b %0d",
                        level, overflow, drop_count, q.size(), m_ovf, m_drops);
            end
         end else begin
            if ($urandom_range(0, 2) == 0) next_addr = $urandom;
            apb_access(r != 2, next_addr, $urandom, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            next_addr = next_addr + 32'd4;
         end
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_second_burst();
      test_overflow();
      test_full_push_pop();
      test_window();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
